// File: rtl/heapsort_sift_down.sv
// rtl/heapsort_sift_down.sv - multi-cycle max-heap sift-down sequencer
module heapsort_sift_down #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic           system1000,
  input  logic           system1000_rstn,
  input  logic           start_i,
  input  logic [15:0]    root_i,
  input  logic [15:0]    size_i,
  input  logic [N*W-1:0] vec_i,
  output logic [N*W-1:0] vec_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [7:0]     swaps_o
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_SWAP, S_DONE} state_t;

  localparam logic [15:0] N16 = 16'(N);

  state_t               state_q, state_d;
  logic [17:0]          cur_q, cur_d;
  logic [17:0]          tgt_q, tgt_d;
  logic [15:0]          sz_q, sz_d;
  logic [7:0]           swaps_q, swaps_d;
  logic signed [W-1:0]  vec_q [N];
  logic signed [W-1:0]  vec_d [N];

  // Child indices are formed at 18 bits so a 16-bit index can never wrap.
  logic [17:0]          l_idx, r_idx, sz18, big;
  logic signed [W-1:0]  v_cur, v_l, v_r, v_big;
  logic [15:0]          sz_clamp;

  assign sz18     = {2'b00, sz_q};
  assign l_idx    = (cur_q << 1) + 18'd1;
  assign r_idx    = (cur_q << 1) + 18'd2;
  assign sz_clamp = (size_i > N16) ? N16 : size_i;

  assign busy_o  = (state_q == S_COMPARE) || (state_q == S_SWAP);
  assign done_o  = (state_q == S_DONE);
  assign swaps_o = swaps_q;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign vec_o[(N-g)*W-1 -: W] = vec_q[g];
  end

  // Element fetch by index match; an index beyond storage simply matches nothing.
  always_comb begin
    v_cur = '0;
    v_l   = '0;
    v_r   = '0;
    for (int k = 0; k < N; k++) begin
      if (cur_q == 18'(k)) v_cur = vec_q[k];
      if (l_idx == 18'(k)) v_l   = vec_q[k];
      if (r_idx == 18'(k)) v_r   = vec_q[k];
    end
  end

  // Pick the largest of parent/left/right; strict compares keep parent on ties, left over right.
  always_comb begin
    big   = cur_q;
    v_big = v_cur;
    if ((l_idx < sz18) && (v_l > v_big)) begin
      big   = l_idx;
      v_big = v_l;
    end
    if ((r_idx < sz18) && (v_r > v_big)) begin
      big = r_idx;
    end
  end

  // Next-state and datapath updates for the IDLE/COMPARE/SWAP/DONE sequence.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    sz_d    = sz_q;
    swaps_d = swaps_q;
    for (int k = 0; k < N; k++) vec_d[k] = vec_q[k];
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int k = 0; k < N; k++) vec_d[k] = vec_i[(N-k)*W-1 -: W];
          cur_d   = {2'b00, root_i};
          sz_d    = sz_clamp;
          swaps_d = '0;
          state_d = (root_i >= sz_clamp) ? S_DONE : S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (big == cur_q) begin
          state_d = S_DONE;
        end else begin
          tgt_d   = big;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        for (int k = 0; k < N; k++) begin
          if (cur_q == 18'(k))      vec_d[k] = vec_q[tgt_q[$clog2(N)-1:0]];
          else if (tgt_q == 18'(k)) vec_d[k] = vec_q[cur_q[$clog2(N)-1:0]];
        end
        cur_d   = tgt_q;
        swaps_d = (swaps_q == 8'hFF) ? swaps_q : swaps_q + 8'd1;
        state_d = S_COMPARE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      sz_q    <= '0;
      swaps_q <= '0;
      for (int k = 0; k < N; k++) vec_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      sz_q    <= sz_d;
      swaps_q <= swaps_d;
      for (int k = 0; k < N; k++) vec_q[k] <= vec_d[k];
    end
  end

endmodule

// File: tb/tb_heapsort_sift_down.sv
// tb/tb_heapsort_sift_down.sv - scoreboard bench for heapsort_sift_down
module tb_heapsort_sift_down;

  localparam int N = 5;
  localparam int W = 32;

  typedef logic signed [W-1:0] arr_t [N];
  typedef struct {
    logic [N*W-1:0] vec;
    logic [7:0]     sw;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start_i;
  logic [15:0]    root_i;
  logic [15:0]    size_i;
  logic [N*W-1:0] vec_i;
  logic [N*W-1:0] vec_o;
  logic           busy_o;
  logic           done_o;
  logic [7:0]     swaps_o;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  heapsort_sift_down #(.N(N), .W(W)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .start_i         (start_i),
    .root_i          (root_i),
    .size_i          (size_i),
    .vec_i           (vec_i),
    .vec_o           (vec_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .swaps_o         (swaps_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] pack(input arr_t a);
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[(N-k)*W-1 -: W] = a[k];
    return p;
  endfunction

  // Reference: classic textbook sift-down on an array, counting exchanges.
  function automatic void model(input arr_t vin, input int root, input int size,
                                output arr_t vout, output int sw, output bit early);
    int sz, c, l, r, big;
    logic signed [W-1:0] t;
    sz = (size > N) ? N : size;
    vout = vin;
    sw = 0;
    early = (root >= sz);
    c = root;
    if (!early) begin
      forever begin
        l = 2 * c + 1;
        r = 2 * c + 2;
        big = c;
        if (l < sz && vout[l] > vout[big]) big = l;
        if (r < sz && vout[r] > vout[big]) big = r;
        if (big == c) break;
        t = vout[c]; vout[c] = vout[big]; vout[big] = t;
        c = big;
        sw++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every done_o pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rstn && done_o) begin
      exp_t e;
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("vec_o", vec_o, e.vec);
        check("swaps_o", {{(N*W-8){1'b0}}, swaps_o}, {{(N*W-8){1'b0}}, e.sw});
        check("done_cycle", (N*W)'(cyc), (N*W)'(e.cyc));
        check("busy_at_done", {{(N*W-1){1'b0}}, busy_o}, '0);
      end
    end
  end

  task automatic run_op(input arr_t v, input int root, input int size,
                        input bit poke, input bit expect_it);
    arr_t ev;
    int sw, t;
    bit early;
    exp_t e;
    model(v, root, size, ev, sw, early);
    @(negedge clk);
    vec_i = pack(v);
    root_i = 16'(root);
    size_i = 16'(size);
    start_i = 1'b1;
    if (expect_it) begin
      e.vec = pack(ev);
      e.sw  = 8'(sw);
      e.cyc = cyc + 1 + (early ? 0 : 1 + 2 * sw);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    vec_i = {N{$urandom()}};
    if (poke) begin
      @(negedge clk);
      start_i = 1'b1;
      root_i = 16'd0;
      size_i = 16'd5;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    if (!expect_it) return;
    t = 0;
    while (!done_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done_o) check("done_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_vec"}, vec_o, '0);
    check({name, "_ctl"}, (N*W)'({busy_o, done_o, swaps_o}), '0);
  endtask

  arr_t v1, v2, v3, vr;

  initial begin
    rstn = 1'b0;
    start_i = 1'b0;
    root_i = '0;
    size_i = '0;
    vec_i = '0;
    v1 = '{1, 5, 3, 4, 2};
    v2 = '{3, 3, 3, 0, 0};
    v3 = '{-1, -5, 7, -9, -8};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    run_op(v1, 0, 5, 1'b0, 1'b1);
    run_op(v2, 0, 5, 1'b0, 1'b1);
    run_op(v3, 0, 5, 1'b0, 1'b1);
    run_op(v1, 0, 2, 1'b0, 1'b1);
    run_op(v1, 0, 9, 1'b0, 1'b1);
    run_op(v1, 3, 5, 1'b0, 1'b1);
    run_op(v1, 0, 5, 1'b1, 1'b1);
    run_op(v1, 0, 0, 1'b0, 1'b1);
    run_op(v1, 0, 1, 1'b0, 1'b1);
    run_op(v1, 65535, 65535, 1'b0, 1'b1);

    // Reset while the first swap of an operation is in progress.
    run_op(v1, 0, 5, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("mid_reset");
    rstn = 1'b1;
    run_op(v1, 0, 5, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++) begin
        if (i % 3 == 0) vr[k] = $urandom();
        else vr[k] = W'($signed($urandom_range(0, 6)) - 3);
      end
      run_op(vr, (i % 7 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5)),
             (i % 5 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 7)),
             1'b0, 1'b1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", (N*W)'(sbq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
